// File: rtl/debounce_multi.sv
// Multi-channel symmetric push-button debouncer with per-channel synchronisers and rise/fall pulses.
// Define DEBOUNCE_LONG_PRESS_EN to build the per-channel long-press detector.
module debounce_multi #(
    parameter int unsigned CH          = 4,
    parameter int unsigned N           = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LONG_N      = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] btn_in,
    output logic [CH-1:0] stable,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] long_press
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

    logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
    logic [CH-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [CH-1:0]                  stable_q, stable_d;
    logic [CH-1:0]                  rise_q, rise_d;
    logic [CH-1:0]                  fall_q, fall_d;
    logic [CH-1:0]                  s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    // Any cycle of agreement restarts the count, so only N consecutive disagreements flip stable.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CntMax) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else begin
                stable_d[i] = s[i];
                cnt_d[i]    = '0;
                rise_d[i]   = s[i];
                fall_d[i]   = ~s[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LcW = (LONG_N > 1) ? $clog2(LONG_N) : 1;
    localparam logic [LcW-1:0] LcMax = LcW'(LONG_N - 1);

    logic [CH-1:0][LcW-1:0] lc_q, lc_d;
    logic [CH-1:0]          done_q, done_d;
    logic [CH-1:0]          long_press_q, long_press_d;

    // done marks that this hold already produced its pulse; lc saturates at LcMax.
    always_comb begin
        lc_d         = lc_q;
        done_d       = done_q;
        long_press_d = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (!stable_q[i]) begin
                lc_d[i]   = '0;
                done_d[i] = 1'b0;
            end else begin
                if (lc_q[i] != LcMax) begin
                    lc_d[i] = lc_q[i] + LcW'(1);
                end
                long_press_d[i] = (lc_q[i] == LcMax) && !done_q[i];
                done_d[i]       = done_q[i] || (lc_q[i] == LcMax);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lc_q         <= '0;
            done_q       <= '0;
            long_press_q <= '0;
        end else begin
            lc_q         <= lc_d;
            done_q       <= done_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = '0;
`endif

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Multi-channel, symmetric push-button debouncer with per-channel input synchronisers and edge-event pulses; the parametrised successor to the single-channel press-only debouncer. Each channel independently filters both press and release. Each channel emits single-cycle `rise`/`fall` events for downstream control logic. An optional long-press detector is compiled in per build. The block sits directly behind the board-level button/switch pins, ahead of any FSM that consumes button events.

## Interface
- `CH`, 4, number of independent channels (≥1)
- `N`, 16, consecutive cycles a synchronised input must disagree with `stable` before `stable` follows it (≥2)
- `SYNC_STAGES`, 2, flip-flops in each input synchroniser (≥2)
- `LONG_N`, 1024, cycles `stable` must remain 1 before `long_press` fires (≥2; used only with the macro)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `btn_in`  in  CH  raw asynchronous button inputs, bit i = channel i
- `stable`  out  CH  debounced level per channel
- `rise`  out  CH  one-cycle pulse when `stable[i]` goes 0→1
- `fall`  out  CH  one-cycle pulse when `stable[i]` goes 1→0
- `long_press`  out  CH  one-cycle pulse on long hold (constant 0 without macro)

## Operation
- Per channel: `SYNC_STAGES`-deep synchroniser chain; its last stage is `s[i]`.
- Per channel: counter `cnt[i]`, width `$clog2(N)`. It counts 0..N-1 and never wraps.
- Each rising clk edge, per channel:
  - if `s[i] == stable[i]`: `cnt[i]` <= 0; `rise`/`fall` <= 0.
  - if `s[i] != stable[i]` and `cnt[i] < N-1`: `cnt[i]` <= `cnt[i]`+1; pulses <= 0.
  - if `s[i] != stable[i]` and `cnt[i] == N-1`: `stable[i]` <= `s[i]`; `cnt[i]` <= 0; `rise[i]` <= `s[i]`; `fall[i]` <= ~`s[i]`.
- Any single-cycle agreement of `s[i]` with `stable[i]` restarts the count from 0. A glitch shorter than N cycles never reaches the output.
- Press and release are filtered identically (symmetric).
- Channels are fully independent. Simultaneous events on several channels all appear on the same edge.
- `rise[i]` and `fall[i]` are never both 1. Each pulse is exactly one cycle wide.

## Timing
- Reset values: all synchroniser flops 0, `cnt` 0, `stable` 0, `rise` 0, `fall` 0, `long_press` 0, long counters 0.
- Latency: `btn_in[i]` changes (held steadily) before edge 0. `stable[i]` and the event pulse update on edge `SYNC_STAGES+N-1`, which is the (SYNC_STAGES+N)-th edge.
- Outputs are registered. There are no combinational paths from `btn_in`.
- Reset asserted mid-count discards all progress. If `btn_in` is already 1 at reset release, a full `SYNC_STAGES+N` cycles elapse before `stable` goes 1, and `rise` fires then.
- No handshake. Consumers must sample the pulses every cycle.

## Configuration
- Macro `DEBOUNCE_LONG_PRESS_EN`.
- With the macro defined, each channel has a saturating counter `lc[i]`, width `$clog2(LONG_N)`:
  - cleared whenever `stable[i]` is 0;
  - increments while `stable[i]` is 1;
  - when `lc[i]` reaches `LONG_N-1`, `long_press[i]` pulses for one cycle and `lc[i]` holds there. No repeat until `stable[i]` returns to 0.
  - `long_press[i]` fires on the edge `LONG_N` cycles after the `rise[i]` edge.
- Without the macro: no long-press counters are synthesised, and `long_press` is tied to 0.

## Test plan
All scenarios use CH=2, N=4, SYNC_STAGES=2, LONG_N=8.
- Reset: assert `rst` with `btn_in`=2'b11 → all outputs 0. Release → `stable[1:0]` goes 2'b11 on the 6th edge, with `rise`=2'b11 for exactly one cycle.
- Clean press/release on ch0: `btn_in[0]` 0→1 → `stable[0]`=1 and `rise[0]` pulse on the 6th edge. Later 1→0 → `fall[0]` pulse on the 6th edge. Ch1 outputs remain 0 throughout.
- Glitch rejection: `btn_in[0]` high for 3 cycles, low 1 cycle, high 3 cycles → `stable[0]` stays 0 and no pulses. Then hold high → `rise[0]` 6 edges after the final rising transition.
- Simultaneous channels: ch0 rises while ch1 (already stable 1) falls on the same cycle → `rise[0]` and `fall[1]` pulse on the same edge.
- Reset mid-count: `btn_in[0]` held 1, `rst` pulsed 2 cycles after the input change → `stable[0]` stays 0. `rise[0]` comes 6 edges after `rst` deasserts.
- Long press (macro on): hold `btn_in[0]`=1 for 30 cycles → exactly one `long_press[0]` pulse, 8 edges after `rise[0]`. With the macro off, `long_press` stays 2'b00.
